// File: rtl/iob_fifo2axis_pkg.sv
// Shared constants and small helpers for the FIFO-to-AXI-Stream read adapter.
// The output buffer holds at most BUF_DEPTH words; level counts them.
package iob_fifo2axis_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int LEVEL_W   = 2;

    typedef enum logic [LEVEL_W-1:0] {
        LVL_EMPTY = 2'd0,
        LVL_ONE   = 2'd1,
        LVL_FULL  = 2'd2
    } level_e;

    function automatic logic [LEVEL_W-1:0] level_of(input logic head_v, input logic skid_v);
        return {1'b0, head_v} + {1'b0, skid_v};
    endfunction

    // Buffer words plus the read already in flight, less this cycle's pop, must leave room.
    function automatic logic room_for_read(input logic [LEVEL_W-1:0] level,
                                           input logic inflight, input logic pop);
        logic [2:0] occ;
        occ = {1'b0, level} + {2'b00, inflight} - {2'b00, pop};
        return (occ < 3'(BUF_DEPTH));
    endfunction

endpackage

// File: rtl/iob_fifo2axis_if.sv
// FIFO read port plus AXI-Stream master signals of the adapter, bundled as one interface.
interface iob_fifo2axis_if #(parameter int DATA_W = 32);

    logic              fifo_empty;
    logic              fifo_read_en;
    logic [DATA_W-1:0] fifo_r_data;
    logic              axis_tvalid;
    logic              axis_tready;
    logic [DATA_W-1:0] axis_tdata;
    logic              axis_tlast;

    modport master (
        input  fifo_empty, fifo_r_data, axis_tready,
        output fifo_read_en, axis_tvalid, axis_tdata, axis_tlast
    );

    modport slave (
        output fifo_empty, fifo_r_data, axis_tready,
        input  fifo_read_en, axis_tvalid, axis_tdata, axis_tlast
    );

endinterface

// File: rtl/iob_fifo2axis_chk.sv
// Invariant checks for the adapter: the buffer is never written while full, AXI data holds under stall.
module iob_fifo2axis_chk
    import iob_fifo2axis_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    input logic               inflight,
    input logic [LEVEL_W-1:0] level,
    input logic               tvalid,
    input logic               tready,
    input logic [DATA_W-1:0]  tdata
);

    a_no_capture_when_full: assert property (@(posedge clk) disable iff (rst)
        !(inflight && (level == LVL_FULL)));

    a_hold_under_stall: assert property (@(posedge clk) disable iff (rst)
        (tvalid && !tready) |=> (tvalid && $stable(tdata)));

endmodule

// File: rtl/iob_skid_buf2.sv
// Two-entry in-order buffer: head drives the output, skid catches a word arriving while head is held.
// The writer guarantees it never pushes into a full buffer.
module iob_skid_buf2
    import iob_fifo2axis_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [LEVEL_W-1:0] level
);

    logic              head_v_r, skid_v_r, head_v_s, skid_v_s;
    logic [DATA_W-1:0] head_r, skid_r, head_s, skid_s;
    logic              pop_s;

    assign pop_s = head_v_r & out_ready;

    // Next-state for both entries; skid always drains into head before head refills from input.
    always_comb begin
        head_v_s = head_v_r;
        skid_v_s = skid_v_r;
        head_s   = head_r;
        skid_s   = skid_r;
        if (pop_s) begin
            if (skid_v_r) begin
                head_s = skid_r;
                if (in_valid) begin
                    skid_s = in_data;
                end else begin
                    skid_v_s = 1'b0;
                end
            end else if (in_valid) begin
                head_s = in_data;
            end else begin
                head_v_s = 1'b0;
            end
        end else if (in_valid) begin
            if (!head_v_r) begin
                head_s   = in_data;
                head_v_s = 1'b1;
            end else begin
                skid_s   = in_data;
                skid_v_s = 1'b1;
            end
        end else begin
            head_v_s = head_v_r;
        end
    end

    // Occupancy flags, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_v_r <= 1'b0;
            skid_v_r <= 1'b0;
        end else begin
            head_v_r <= head_v_s;
            skid_v_r <= skid_v_s;
        end
    end

    // Payload registers carry no reset; they are only observed while their flag is set.
    always_ff @(posedge clk) begin
        head_r <= head_s;
        skid_r <= skid_s;
    end

    assign out_valid = head_v_r;
    assign out_data  = head_r;
    assign level     = level_of(head_v_r, skid_v_r);

endmodule

// File: rtl/iob_fifo2axis.sv
// FIFO read-port to AXI-Stream master adapter: prefetches into a 2-entry buffer and frames
// the stream with tlast every len beats (len=0 streams without tlast).
module iob_fifo2axis
    import iob_fifo2axis_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [LEN_W-1:0]   len,
    output logic               frame_done,
    output logic [LEVEL_W-1:0] level,
    iob_fifo2axis_if.master    bus
);

    logic             inflight_r;
    logic             read_en_s;
    logic             tvalid_s;
    logic             tlast_s;
    logic             pop_s;
    logic [LEN_W-1:0] beat_cnt_r;
    logic             frame_done_r;

    iob_skid_buf2 #(.DATA_W(DATA_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_r),
        .in_data   (bus.fifo_r_data),
        .out_ready (bus.axis_tready),
        .out_valid (tvalid_s),
        .out_data  (bus.axis_tdata),
        .level     (level)
    );

    assign pop_s = tvalid_s & bus.axis_tready;

    // The >= compare ends the frame promptly if len shrinks below the current position.
    always_comb begin
        tlast_s = 1'b0;
        if (tvalid_s && (len != '0)) begin
            tlast_s = (beat_cnt_r >= (len - LEN_W'(1)));
        end else begin
            tlast_s = 1'b0;
        end
    end

    assign read_en_s = en & ~bus.fifo_empty & ~rst & room_for_read(level, inflight_r, pop_s);

    // A read issued just before reset returns during reset and is dropped with inflight.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r   <= 1'b0;
            beat_cnt_r   <= '0;
            frame_done_r <= 1'b0;
        end else begin
            inflight_r   <= read_en_s;
            frame_done_r <= pop_s & tlast_s;
            if (pop_s) begin
                beat_cnt_r <= tlast_s ? '0 : (beat_cnt_r + LEN_W'(1));
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
        end
    end

    assign bus.fifo_read_en = read_en_s;
    assign bus.axis_tvalid  = tvalid_s;
    assign bus.axis_tlast   = tlast_s;
    assign frame_done       = frame_done_r;

    iob_fifo2axis_chk #(.DATA_W(DATA_W)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .inflight (inflight_r),
        .level    (level),
        .tvalid   (tvalid_s),
        .tready   (bus.axis_tready),
        .tdata    (bus.axis_tdata)
    );

endmodule

// File: tb/tb_iob_fifo2axis.sv
// Bench for iob_fifo2axis: queue-based FIFO and stream reference model, a framing table,
// directed corner sequences and a randomized run.
module tb_iob_fifo2axis;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [LEN_W-1:0]  len;
    logic              frame_done;
    logic [1:0]        level;

    iob_fifo2axis_if #(.DATA_W(DATA_W)) bus ();

    iob_fifo2axis #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .len        (len),
        .frame_done (frame_done),
        .level      (level),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] fq[$];
    logic [31:0] exp_q[$];
    int          infl_m, pos_m;
    bit          exp_fd, armed;
    int          n_vec, n_fail;

    bit          s_rst, s_rd, s_pop, s_tvalid, s_tlast, s_fd, s_pop_m, s_last_exp;
    logic [31:0] s_tdata;
    logic [1:0]  s_level;

    typedef struct {
        bit          tready;
        bit          rd;
        bit          tvalid;
        logic [31:0] tdata;
        bit          tlast;
        bit          fd;
        logic [1:0]  lvl;
    } vec_t;
    vec_t tbl[10];

    function void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    // One clock: sample and check at the falling edge, then advance FIFO and reference model.
    task automatic cycle();
        int          lvl_m;
        bit          exp_rd;
        logic [31:0] w;
        bus.fifo_empty = (fq.size() == 0);
        @(negedge clk);
        s_rst    = rst;
        s_rd     = bus.fifo_read_en;
        s_tvalid = bus.axis_tvalid;
        s_tdata  = bus.axis_tdata;
        s_tlast  = bus.axis_tlast;
        s_pop    = bus.axis_tvalid & bus.axis_tready;
        s_fd     = frame_done;
        s_level  = level;
        lvl_m      = exp_q.size() - infl_m;
        s_pop_m    = (lvl_m > 0) && bus.axis_tready;
        s_last_exp = (lvl_m > 0) && (len != 0) && (pos_m >= int'(len) - 1);
        if (armed) begin
            exp_rd = en && !bus.fifo_empty && !rst && ((exp_q.size() - int'(s_pop_m)) < 2);
            chk("read_en", 32'(s_rd), 32'(exp_rd));
            chk("tvalid", 32'(s_tvalid), 32'(lvl_m > 0));
            chk("level", 32'(s_level), 32'(lvl_m));
            chk("frame_done", 32'(s_fd), 32'(exp_fd));
            if (lvl_m > 0) begin
                chk("tdata", s_tdata, exp_q[0]);
            end
            chk("tlast", 32'(s_tlast), 32'(s_last_exp));
        end
        @(posedge clk);
        #1;
        if (s_rd && fq.size() > 0) begin
            w = fq.pop_front();
            bus.fifo_r_data = w;
        end else begin
            w = 32'h0;
        end
        if (s_rst) begin
            exp_q.delete();
            pos_m  = 0;
            infl_m = 0;
            exp_fd = 1'b0;
            armed  = 1'b1;
        end else begin
            if (s_pop_m) begin
                void'(exp_q.pop_front());
                pos_m = s_last_exp ? 0 : ((pos_m + 1) % 65536);
            end
            exp_fd = s_pop_m && s_last_exp;
            if (s_rd) exp_q.push_back(w);
            infl_m = int'(s_rd);
        end
    endtask

    initial begin
        int first_rd, first_v, first_pop, last_pop, nbeats, nlast, tl_idx, bad_rd;
        bit got;
        logic [31:0] d, nxt;
        n_vec = 0; n_fail = 0; armed = 1'b0;
        infl_m = 0; pos_m = 0; exp_fd = 1'b0;
        rst = 1'b1; en = 1'b0; len = '0;
        bus.axis_tready = 1'b0; bus.fifo_r_data = 32'h0; bus.fifo_empty = 1'b1;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'hA0, 1'b0, 1'b0, 2'd1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b0, 2'd1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'hA2, 1'b1, 1'b0, 2'd1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'hA3, 1'b0, 1'b1, 2'd1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'hA4, 1'b0, 1'b0, 2'd1};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 32'hA5, 1'b1, 1'b0, 2'd1};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 32'hA6, 1'b0, 1'b1, 2'd1};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0};

        // Reset held with a non-empty FIFO and en=1: nothing may be read or presented.
        fq.push_back(32'h1); fq.push_back(32'h2); fq.push_back(32'h3);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rst_read_en", 32'(s_rd), 32'h0);
            if (i > 0) begin
                chk("rst_tvalid", 32'(s_tvalid), 32'h0);
                chk("rst_level", 32'(s_level), 32'h0);
            end
        end
        rst = 1'b0; bus.axis_tready = 1'b1;
        repeat (8) cycle();

        // Stream of 8 words, len=0.
        for (int i = 0; i < 8; i++) fq.push_back(32'h10 + 32'(i));
        first_rd = -1; first_v = -1; first_pop = -1; last_pop = -1; nbeats = 0; nlast = 0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (s_rd && first_rd < 0) first_rd = i;
            if (s_tvalid && first_v < 0) first_v = i;
            if (s_pop) begin
                if (first_pop < 0) first_pop = i;
                last_pop = i;
                nbeats++;
                if (s_tlast) nlast++;
            end
        end
        chk("stream_latency", 32'(first_v - first_rd), 32'd2);
        chk("stream_beats", 32'(nbeats), 32'd8);
        chk("stream_back_to_back", 32'(last_pop - first_pop), 32'd7);
        chk("stream_no_tlast", 32'(nlast), 32'd0);

        // Backpressure: tready 1,0,0,1,0,0,...
        for (int i = 0; i < 8; i++) fq.push_back(32'h20 + 32'(i));
        nbeats = 0;
        for (int i = 0; i < 40; i++) begin
            bus.axis_tready = (i % 3 == 0);
            cycle();
            if (s_pop) nbeats++;
        end
        chk("bp_beats", 32'(nbeats), 32'd8);

        // Framing table, len=3, 7 words.
        rst = 1'b1; en = 1'b0; bus.axis_tready = 1'b1; len = 16'd3;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) fq.push_back(32'hA0 + 32'(i));
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.axis_tready = tbl[i].tready;
            cycle();
            chk($sformatf("tbl%0d_read_en", i), 32'(s_rd), 32'(tbl[i].rd));
            chk($sformatf("tbl%0d_tvalid", i), 32'(s_tvalid), 32'(tbl[i].tvalid));
            if (tbl[i].tvalid) chk($sformatf("tbl%0d_tdata", i), s_tdata, tbl[i].tdata);
            chk($sformatf("tbl%0d_tlast", i), 32'(s_tlast), 32'(tbl[i].tlast));
            chk($sformatf("tbl%0d_frame_done", i), 32'(s_fd), 32'(tbl[i].fd));
            chk($sformatf("tbl%0d_level", i), 32'(s_level), 32'(tbl[i].lvl));
        end
        // beat_cnt is 1 after beat 7, so the second of the next two beats closes the frame.
        fq.push_back(32'hB0); fq.push_back(32'hB1);
        nlast = 0; d = 32'h0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (s_pop && s_tlast) begin nlast++; d = s_tdata; end
        end
        chk("frame_carry_tlasts", 32'(nlast), 32'd1);
        chk("frame_carry_word", d, 32'hB1);

        // FIFO runs empty, refills, then en drops mid-frame (len=4).
        rst = 1'b1; len = 16'd4; cycle(); rst = 1'b0;
        fq.push_back(32'hC0); fq.push_back(32'hC1);
        nbeats = 0; nlast = 0; tl_idx = -1; bad_rd = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 9) for (int k = 0; k < 6; k++) fq.push_back(32'hC2 + 32'(k));
            en = !(i >= 9 && i < 13);
            cycle();
            if (s_rd && (!en || bus.fifo_empty)) bad_rd++;
            if (s_pop) begin
                nbeats++;
                if (s_tlast) begin
                    nlast++;
                    if (tl_idx < 0) tl_idx = nbeats;
                end
            end
        end
        chk("gap_illegal_reads", 32'(bad_rd), 32'd0);
        chk("gap_beats", 32'(nbeats), 32'd8);
        chk("gap_tlasts", 32'(nlast), 32'd2);
        chk("gap_first_tlast_beat", 32'(tl_idx), 32'd4);

        // Reset with a full buffer; output resumes with the next FIFO word.
        rst = 1'b1; len = '0; en = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 10; i++) fq.push_back(32'hD0 + 32'(i));
        bus.axis_tready = 1'b0;
        repeat (4) cycle();
        chk("midrst_pre_level", 32'(s_level), 32'd2);
        rst = 1'b1; cycle(); rst = 1'b0;
        nxt = fq[0];
        cycle();
        chk("midrst_tvalid", 32'(s_tvalid), 32'h0);
        chk("midrst_level", 32'(s_level), 32'h0);
        bus.axis_tready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_pop && !got) begin
                got = 1'b1;
                chk("midrst_resume_word", s_tdata, nxt);
            end
        end
        if (!got) chk("midrst_resume_timeout", 32'h0, 32'h1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 16) fq.push_back($urandom);
            bus.axis_tready = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 39) == 0) len = LEN_W'($urandom_range(0, 5));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
